jk_stimulus_checker: RTL and testbench
======================================

Name: jk_stimulus_checker

Overview:
- Self-checking stimulus stage that sits directly upstream of the JK flip-flop instances.
- On `start` it drives a fixed J/K step sequence into the DUT's J/K inputs, with each step held for `HOLD_CYCLES` clocks.
- It keeps a golden JK model in lock-step with the DUT and compares the DUT's `Q`/`Qp` against it every cycle.
- It reports a saturating mismatch count and a one-cycle `done` pulse, replacing the hand-timed delay stimulus used in current top-levels.

Parameters:
- `HOLD_CYCLES`, 5, clocks each step's J/K pair is held (must be ≥1).
- `NUM_STEPS`, 8, number of sequence steps; fixed table in package, ≤8.
- `ERR_W`, 8, width of the mismatch counter.

Ports:
- `clkin`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled in IDLE only.
- `J`  out  1  registered J drive to the DUT.
- `K`  out  1  registered K drive to the DUT.
- `Q_dut`  in  1  DUT Q output.
- `Qp_dut`  in  1  DUT complement output.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `err_count`  out  `ERR_W`  saturating count of mismatching compare cycles.
- `step_idx`  out  3  current step index, for waveform debug.

Behaviour:
- Interface (already decided): one clock, `clkin`; reset `rst_n` is asynchronous and active-low.
- Reset values: `J`=0, `K`=0, `busy`=0, `done`=0, `err_count`=0, `step_idx`=0, `q_ref`=0, state IDLE, hold counter 0.
- All outputs are registered. J/K change on a `clkin` rising edge. The DUT and the golden model both sample them on the next edge.
- Golden model `q_ref`, from registered J/K: 00 hold, 01 clear to 0, 10 set to 1, 11 toggle.
- Compare timing: a compare at edge n checks DUT/`q_ref` values produced at edge n-1.
- Mismatch rule: `Q_dut` ≠ `q_ref` OR `Qp_dut` ≠ ~`Q_dut`. Either or both count once per cycle.
- `err_count` saturates at all-ones; it never wraps.
- States:
  - IDLE: J=K=0. If `start`=1: clear `err_count`, go to SEED.
  - SEED: 2 cycles, J=0, K=1. Forces DUT and `q_ref` to 0; no compares. Then go to RUN.
  - RUN: steps 0..`NUM_STEPS`-1, each `HOLD_CYCLES` cycles, J/K from the step table. Compares are enabled on every RUN cycle except the first.
  - DRAIN: 1 cycle, J=K=0. Performs the final compare.
  - DONE: `done`=1 for 1 cycle, `busy` drops, return to IDLE.
- Step table, (J,K) per step: 0:(1,1), 1:(1,0), 2:(0,0), 3:(0,1), 4:(1,1), 5:(0,0), 6:(1,0), 7:(0,1).
- `start` asserted while `busy` is ignored; no restart, no queuing.
- `start` held high through DONE begins a new run from IDLE on the following cycle.
- Reset asserted mid-run: immediate return to the reset values, independent of the clock.
- Total run length, with the `start` edge as cycle 0: 2 + `NUM_STEPS`·`HOLD_CYCLES` + 1, then `done`. With defaults, `done` is high in cycle 44.
- Compares per run: `NUM_STEPS`·`HOLD_CYCLES` (39 in RUN plus 1 in DRAIN at defaults).

Decomposition:
- Package `jk_stim_pkg`:
  - state enum IDLE/SEED/RUN/DRAIN/DONE;
  - `SEED_CYCLES`=2;
  - step-table constants `STEP_J`/`STEP_K` as 8-bit vectors;
  - JK-encoding constants HOLD/RST/SET/TOG.
- Sub-module `jk_ref_model` holds the golden JK register: inputs `clkin`, `rst_n`, J, K; output `q_ref`.
- The FSM, hold counter and error counter stay in the top module.

Test Plan:
- Correct DUT (the existing JK flip-flop, async-reset compatible), `start` pulse at cycle 0 → `busy`=1 cycles 1–43, `done`=1 in cycle 44, `err_count`=0, final `q_ref`=0.
- `Q_dut` stuck at 0, `Qp_dut` stuck at 1 → `err_count`=26 at `done`. Ones in `q_ref` per step: 3, 5, 5, 0, 3, 5, 5, 0.
- `Qp_dut` tied to `Q_dut` with a correct Q → every compare fails, `err_count`=40. Rerun with `ERR_W`=4 → `err_count`=15, no wrap.
- `start` re-pulsed at cycles 10 and 30 → ignored; `done` still at cycle 44, exactly one `done` pulse.
- `rst_n` low at cycle 20 for 3 cycles → all outputs at reset values immediately. A fresh `start` then completes a full 44-cycle run with `err_count`=0.
- `HOLD_CYCLES`=1 with a correct DUT → `done` in cycle 12, `err_count`=0; J/K change on every edge in RUN.

Source files
------------

// File: rtl/jk_stim_pkg.sv
// Shared types and constants for the JK stimulus/checker block: FSM states,
// the fixed J/K step table and the JK input encoding.
package jk_stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int SEED_CYCLES = 2;

  // Bit i of each vector is the J (resp. K) level for step i.
  localparam logic [7:0] STEP_J = 8'b0101_0011;
  localparam logic [7:0] STEP_K = 8'b1001_1001;

  // {J,K} encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TOG:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_ref_model.sv
// Golden JK register; samples the same registered J/K that the DUT sees.
module jk_ref_model
  import jk_stim_pkg::*;
(
  input  logic clkin,
  input  logic rst_n,
  input  logic J,
  input  logic K,
  output logic q_ref
);

  logic q_ref_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      q_ref_q <= 1'b0;
    end else begin
      q_ref_q <= jk_next(q_ref_q, J, K);
    end
  end

  assign q_ref = q_ref_q;

endmodule

// File: rtl/jk_stimulus_checker.sv
// Drives a fixed J/K step sequence into a JK flip-flop, tracks a golden model
// in lock-step and counts cycles where the DUT's Q/Qp disagree with it.
module jk_stimulus_checker
  import jk_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 5,
  parameter int NUM_STEPS   = 8,
  parameter int ERR_W       = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             start,
  output logic             J,
  output logic             K,
  input  logic             Q_dut,
  input  logic             Qp_dut,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       step_idx
);

  localparam int CNT_MAX = (HOLD_CYCLES > SEED_CYCLES) ? HOLD_CYCLES : SEED_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(SEED_CYCLES - 1);
  localparam logic [2:0]       STEP_LAST = 3'(NUM_STEPS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       step_q, step_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic q_ref;
  logic mismatch;
  logic cmp_en;

  jk_ref_model u_ref (
    .clkin (clkin),
    .rst_n (rst_n),
    .J     (j_q),
    .K     (k_q),
    .q_ref (q_ref)
  );

  assign mismatch = (Q_dut != q_ref) || (Qp_dut != ~Q_dut);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step_d  = step_q;
    err_d   = err_q;
    cmp_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEED;
          hold_d  = '0;
          step_d  = '0;
          err_d   = '0;
        end
      end
      SEED: begin
        if (hold_q == SEED_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        // The first RUN cycle still shows the seeded value, so it is not judged.
        cmp_en = (step_q != '0) || (hold_q != '0);
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (step_q == STEP_LAST) begin
            state_d = DRAIN;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DRAIN: begin
        cmp_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cmp_en && mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end

    // Outputs are decoded from the next state so they are registered with it.
    j_d    = 1'b0;
    k_d    = 1'b0;
    busy_d = (state_d == SEED) || (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    case (state_d)
      SEED: k_d = 1'b1;
      RUN: begin
        j_d = STEP_J[step_d];
        k_d = STEP_K[step_d];
      end
      default: begin
        j_d = 1'b0;
        k_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      step_q  <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign J         = j_q;
  assign K         = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_jk_stimulus_checker.sv
// Randomised bench for jk_stimulus_checker: emulated JK DUTs with selectable
// faults, a cycle-level model of the run schedule and literal pinned results.
module tb_jk_stimulus_checker;

  localparam int H     = 5;
  localparam int NS    = 8;
  localparam int LAST  = 2 + NS * H + 2;  // cycle of the done pulse (44)
  localparam int HB    = 1;
  localparam int ERRBW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             startA, startB;
  logic             JA, KA, QA, QpA, busyA, doneA;
  logic [7:0]       errA;
  logic [2:0]       stepA;
  logic             JB, KB, QB, QpB, busyB, doneB;
  logic [ERRBW-1:0] errB;
  logic [2:0]       stepB;

  int   modeA, modeB;
  logic qa_emu, qb_emu, noise;
  int   total = 0;
  int   bad = 0;

  jk_stimulus_checker #(.HOLD_CYCLES(H), .NUM_STEPS(NS), .ERR_W(8)) dut_a (
    .clkin(clk), .rst_n(rst_n), .start(startA), .J(JA), .K(KA),
    .Q_dut(QA), .Qp_dut(QpA), .busy(busyA), .done(doneA),
    .err_count(errA), .step_idx(stepA)
  );

  jk_stimulus_checker #(.HOLD_CYCLES(HB), .NUM_STEPS(8), .ERR_W(ERRBW)) dut_b (
    .clkin(clk), .rst_n(rst_n), .start(startB), .J(JB), .K(KB),
    .Q_dut(QB), .Qp_dut(QpB), .busy(busyB), .done(doneB),
    .err_count(errB), .step_idx(stepB)
  );

  // Emulated flip-flops under test (async-reset JK).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qa_emu <= 1'b0;
    else case ({JA, KA})
      2'b01:   qa_emu <= 1'b0;
      2'b10:   qa_emu <= 1'b1;
      2'b11:   qa_emu <= ~qa_emu;
      default: qa_emu <= qa_emu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qb_emu <= 1'b0;
    else case ({JB, KB})
      2'b01:   qb_emu <= 1'b0;
      2'b10:   qb_emu <= 1'b1;
      2'b11:   qb_emu <= ~qb_emu;
      default: qb_emu <= qb_emu;
    endcase
  end

  always_ff @(posedge clk) noise <= ($urandom_range(0, 3) == 0);

  // modes: 0 correct, 1 Q stuck 0 / Qp stuck 1, 2 Qp tied to Q, 3 random Q glitches
  always_comb begin
    QA  = qa_emu;
    QpA = ~qa_emu;
    case (modeA)
      1: begin QA = 1'b0; QpA = 1'b1; end
      2: QpA = qa_emu;
      3: begin QA = qa_emu ^ noise; QpA = ~(qa_emu ^ noise); end
      default: ;
    endcase
  end

  assign QB  = qb_emu;
  assign QpB = (modeB != 0) ? qb_emu : ~qb_emu;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] step_jk(input int s);
    logic [1:0] r;
    case (s)
      0: r = 2'b11;  1: r = 2'b10;  2: r = 2'b00;  3: r = 2'b01;
      4: r = 2'b11;  5: r = 2'b00;  6: r = 2'b10;  7: r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // {J,K} visible in cycle c of a run (cycle 0 = start edge)
  function automatic logic [1:0] exp_jk(input int c, input int h);
    if (c >= 1 && c <= 2) return 2'b01;
    if (c >= 3 && c <= 2 + NS * h) return step_jk((c - 3) / h);
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic jk_rule(input logic q, input logic [1:0] jk);
    if (jk == 2'b01) return 1'b0;
    if (jk == 2'b10) return 1'b1;
    if (jk == 2'b11) return ~q;
    return q;
  endfunction

  // Model of instance A: m_d = edges since the accepted start edge.
  bit   m_act;
  int   m_d, m_cnt;
  logic mq;

  initial begin : model
    logic [1:0] jj;
    m_act = 1'b0; m_d = 0; m_cnt = 0; mq = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 1'b0; m_d = 0; m_cnt = 0; mq = 1'b0;
      end else begin
        if (m_act) begin
          m_d++;
          if (m_d > LAST) m_act = 1'b0;
        end
        if (!m_act && startA) begin
          m_act = 1'b1; m_d = 0; m_cnt = 0;
        end
        if (m_act && m_d >= 4 && m_d <= LAST - 1) begin
          if (QA !== mq || QpA !== ~QA) m_cnt++;
        end
        jj = m_act ? exp_jk(m_d, H) : 2'b00;
        mq = jk_rule(mq, jj);
      end
    end
  end

  initial begin : compare
    int c;
    forever begin
      @(negedge clk);
      c = m_d + 1;
      chk("busy", 32'(busyA), 32'(m_act && c <= LAST - 1));
      chk("done", 32'(doneA), 32'(m_act && c == LAST));
      chk("jk", 32'({JA, KA}), 32'(m_act ? exp_jk(c, H) : 2'b00));
      chk("err", 32'(errA), 32'(sat(m_cnt, 8)));
      if (m_act && c >= 3 && c <= 2 + NS * H) chk("step", 32'(stepA), 32'((c - 3) / H));
    end
  end

  task automatic run_a(input int md, input bit repulse, input int rst_at, input bit hold,
                       input int exp_err);
    int k;
    bit seen;
    modeA = md;
    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    startA = 1'b1;
    @(posedge clk); #1;
    if (!hold) startA = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k <= LAST + 20) begin
      if (repulse && (k == 10 || k == 30)) startA = 1'b1;
      else if (!hold) startA = 1'b0;
      if (rst_at != 0 && k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busyA), 0);
        chk("rst_done", 32'(doneA), 0);
        chk("rst_jk", 32'({JA, KA}), 0);
        chk("rst_err", 32'(errA), 0);
        chk("rst_step", 32'(stepA), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        startA = 1'b0;
        return;
      end
      if (doneA) begin
        seen = 1'b1;
        chk("done_cycle", 32'(k), 44);
        if (exp_err >= 0) chk("run_err", 32'(errA), 32'(exp_err));
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    if (!hold) startA = 1'b0;
    if (seen) begin
      @(posedge clk); #1;
      chk("post_done", 32'(doneA), 0);
      chk("post_busy", 32'(busyA), 0);
      if (hold) begin
        @(posedge clk); #1;
        chk("restart_busy", 32'(busyA), 1);
        startA = 1'b0;
        k = 0;
        while (!doneA && k < 100) begin @(posedge clk); #1; k++; end
        chk("restart_done", 32'(doneA), 1);
      end
    end
  endtask

  task automatic run_b(input int md, input int exp_err);
    int k;
    bit seen;
    modeB = md;
    @(posedge clk); #1;
    startB = 1'b1;
    @(posedge clk); #1;
    startB = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 40) begin
      if (k >= 3 && k <= 2 + NS * HB) begin
        chk("b_jk", 32'({JB, KB}), 32'(step_jk((k - 3) / HB)));
        chk("b_step", 32'(stepB), 32'((k - 3) / HB));
      end
      if (doneB) begin
        seen = 1'b1;
        chk("b_done_cycle", 32'(k), 12);
        chk("b_err", 32'(errB), 32'(exp_err));
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!seen) chk("b_done_timeout", 0, 1);
  endtask

  initial begin : stim
    rst_n = 1'b0; startA = 1'b0; startB = 1'b0; modeA = 0; modeB = 0;
    #12;
    chk("init_busy", 32'(busyA), 0);
    chk("init_done", 32'(doneA), 0);
    chk("init_err", 32'(errA), 0);
    chk("init_b_jk", 32'({JB, KB}), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_a(0, 1'b1, 0, 1'b0, 0);   // correct DUT, start re-pulsed at 10 and 30
    run_a(1, 1'b0, 0, 1'b0, 26);  // Q stuck 0 / Qp stuck 1
    run_a(2, 1'b0, 0, 1'b0, 40);  // Qp tied to Q: every compare fails
    run_a(0, 1'b0, 20, 1'b0, -1); // reset mid-run
    run_a(0, 1'b0, 0, 1'b0, 0);   // fresh run after reset
    run_a(0, 1'b0, 0, 1'b1, 0);   // start held through DONE
    repeat (8) begin
      run_a($urandom_range(0, 3), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40) : 0, 1'b0, -1);
    end

    run_b(0, 0);  // HOLD_CYCLES=1, correct DUT
    run_b(1, 7);  // 8 failing compares saturate a 3-bit counter

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
